dequantizer: RTL and testbench

DEQUANTIZER -- requirements
Module: dequantizer

---
 rtl/dequantizer.sv | 168 ++++++++++++++++
 tb/tb_dequantizer.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dequantizer.sv
`default_nettype none
// ============================================================================
// Module   : dequantizer
// Brief    : JPEG-style 8x8 block dequantizer. A captured coefficient block
//            is multiplied row by row (one row per cycle) with the per-channel
//            quantization table and presented to the IDCT with a one-cycle
//            valid pulse, 9 cycles after valid_in.
// Options  : DEQUANT_SAT_EN -- when defined, products saturate to the signed
//            OUT_W range; otherwise they wrap to their low OUT_W bits.
// Revision : 1.0 - initial release
// ============================================================================
module dequantizer #(
  parameter int IN_W  = 12,
  parameter int Q_W   = 8,
  parameter int OUT_W = 16,
  parameter int NCH   = 3
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic signed [7:0][7:0][IN_W-1:0]    block_in,
  input  logic                                valid_in,
  input  logic        [$clog2(NCH+1)-1:0]     ch_in,
  input  logic                                qt_wr_en,
  input  logic        [$clog2(NCH+1)-1:0]     qt_wr_ch,
  input  logic        [5:0]                   qt_wr_addr,
  input  logic        [Q_W-1:0]               qt_wr_data,
  output logic signed [7:0][7:0][OUT_W-1:0]   block_out,
  output logic                                valid_out,
  output logic        [$clog2(NCH+1)-1:0]     ch_out,
  output logic                                busy,
  output logic                                overrun
);

  localparam int CH_W   = $clog2(NCH + 1);
  localparam int TS_W   = (NCH > 1) ? $clog2(NCH) : 1;
  // signed coefficient times zero-extended unsigned entry
  localparam int PROD_W = IN_W + Q_W + 1;
  localparam logic [CH_W-1:0] C_NCH = CH_W'(NCH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                          state_q;
  logic [2:0]                      row_q;
  logic [7:0][7:0][IN_W-1:0]       blk_q;
  logic [CH_W-1:0]                 ch_q;
  logic [7:0][7:0][OUT_W-1:0]      block_out_q;
  logic                            valid_out_q;
  logic                            busy_q;
  logic                            overrun_q;

  logic [Q_W-1:0]                  tbl_q [NCH][64];

  logic [TS_W-1:0]                 w_tsel;
  logic                            w_wr_ok;
  logic signed [PROD_W-1:0]        w_a   [8];
  logic signed [PROD_W-1:0]        w_b   [8];
  logic [OUT_W-1:0]                w_row [8];

`ifdef DEQUANT_SAT_EN
  localparam logic signed [PROD_W-1:0] C_SAT_MAX = PROD_W'(2 ** (OUT_W - 1) - 1);
  localparam logic signed [PROD_W-1:0] C_SAT_MIN = ~C_SAT_MAX;
  logic signed [PROD_W-1:0]        w_p;
`endif

  // Out-of-range channels fall back to table 0; out-of-range writes are dropped.
  assign w_tsel  = (ch_q < C_NCH) ? ch_q[TS_W-1:0] : '0;
  assign w_wr_ok = qt_wr_en && (qt_wr_ch < C_NCH);

  // Quantization tables: reset to identity, writable in any state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int t = 0; t < NCH; t++) begin
        for (int a = 0; a < 64; a++) begin
          tbl_q[t][a] <= Q_W'(1);
        end
      end
    end else if (w_wr_ok) begin
      tbl_q[qt_wr_ch[TS_W-1:0]][qt_wr_addr] <= qt_wr_data;
    end
  end

  // Multiply the current row of the captured block by its table row.
  always_comb begin
`ifdef DEQUANT_SAT_EN
    w_p = '0;
`endif
    for (int c = 0; c < 8; c++) begin
      w_a[c] = PROD_W'($signed(blk_q[row_q][c]));
      w_b[c] = PROD_W'({1'b0, tbl_q[w_tsel][{row_q, 3'(c)}]});
`ifdef DEQUANT_SAT_EN
      w_p = w_a[c] * w_b[c];
      if (w_p > C_SAT_MAX) begin
        w_row[c] = C_SAT_MAX[OUT_W-1:0];
      end else if (w_p < C_SAT_MIN) begin
        w_row[c] = C_SAT_MIN[OUT_W-1:0];
      end else begin
        w_row[c] = w_p[OUT_W-1:0];
      end
`else
      w_row[c] = OUT_W'(w_a[c] * w_b[c]);
`endif
    end
  end

  // Block sequencer: capture in IDLE, one row per RUN cycle, pulse in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      row_q       <= 3'd0;
      blk_q       <= '0;
      ch_q        <= '0;
      block_out_q <= '0;
      valid_out_q <= 1'b0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      valid_out_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (valid_in) begin
            blk_q   <= block_in;
            ch_q    <= ch_in;
            row_q   <= 3'd0;
            state_q <= ST_RUN;
            busy_q  <= 1'b1;
          end
        end
        ST_RUN: begin
          for (int c = 0; c < 8; c++) begin
            block_out_q[row_q][c] <= w_row[c];
          end
          if (valid_in) begin
            overrun_q <= 1'b1;
          end
          if (row_q == 3'd7) begin
            state_q     <= ST_DONE;
            valid_out_q <= 1'b1;
          end else begin
            row_q <= row_q + 3'd1;
          end
        end
        ST_DONE: begin
          if (valid_in) begin
            overrun_q <= 1'b1;
          end
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign block_out = block_out_q;
  assign valid_out = valid_out_q;
  assign ch_out    = ch_q;
  assign busy      = busy_q;
  assign overrun   = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_dequantizer.sv
`default_nettype none
// ============================================================================
// Module   : tb_dequantizer
// Brief    : Self-checking bench for dequantizer (vector table, directed
//            multi-cycle sequences, randomized blocks against a model).
// Revision : 1.0 - initial release
// ============================================================================
module tb_dequantizer;

  localparam int IN_W  = 12;
  localparam int Q_W   = 8;
  localparam int OUT_W = 16;
  localparam int NCH   = 3;
  localparam int CH_W  = 2;

  logic                              clk = 1'b0;
  logic                              rst_n;
  logic signed [7:0][7:0][IN_W-1:0]  block_in;
  logic                              valid_in;
  logic        [CH_W-1:0]            ch_in;
  logic                              qt_wr_en;
  logic        [CH_W-1:0]            qt_wr_ch;
  logic        [5:0]                 qt_wr_addr;
  logic        [Q_W-1:0]             qt_wr_data;
  logic signed [7:0][7:0][OUT_W-1:0] block_out;
  logic                              valid_out;
  logic        [CH_W-1:0]            ch_out;
  logic                              busy;
  logic                              overrun;

  dequantizer #(.IN_W(IN_W), .Q_W(Q_W), .OUT_W(OUT_W), .NCH(NCH)) dut (
    .clk(clk), .rst_n(rst_n), .block_in(block_in), .valid_in(valid_in),
    .ch_in(ch_in), .qt_wr_en(qt_wr_en), .qt_wr_ch(qt_wr_ch),
    .qt_wr_addr(qt_wr_addr), .qt_wr_data(qt_wr_data), .block_out(block_out),
    .valid_out(valid_out), .ch_out(ch_out), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  typedef int blk_t [8][8];
  typedef struct {
    int ch; int x00; int xr; int e00; int er;
  } vec_t;

  int   errors = 0;
  int   checks = 0;
  int   qt_m [NCH][64];
  vec_t vecs [7];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Spec-level rule: product of signed coefficient and unsigned entry,
  // then clamp or wrap to OUT_W.
  function automatic int dq(input int x, input int q);
    int p;
    logic [OUT_W-1:0] lo;
    p  = x * q;
    lo = p[OUT_W-1:0];
`ifdef DEQUANT_SAT_EN
    if (p > 32767) return 32767;
    if (p < -32768) return -32768;
    return p;
`else
    return int'($signed(lo));
`endif
  endfunction

  task automatic model(input blk_t b, input int ch, output blk_t e);
    int t;
    t = (ch < NCH) ? ch : 0;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        e[r][c] = dq(b[r][c], qt_m[t][r*8+c]);
  endtask

  task automatic model_reset();
    for (int t = 0; t < NCH; t++)
      for (int a = 0; a < 64; a++)
        qt_m[t][a] = 1;
  endtask

  task automatic drive_blk(input blk_t b);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        block_in[r][c] = IN_W'(b[r][c]);
  endtask

  task automatic fill(output blk_t b, input int v00, input int vr);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        b[r][c] = vr;
    b[0][0] = v00;
  endtask

  task automatic check_blk(input string name, input blk_t e);
    int bad = -1;
    int got = 0;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        if (bad < 0 && int'($signed(block_out[r][c])) != e[r][c]) begin
          bad = r * 8 + c;
          got = int'($signed(block_out[r][c]));
        end
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("FAIL %s: entry %0d got %0d expected %0d", name, bad, got, e[bad/8][bad%8]);
    end
  endtask

  task automatic qt_write(input int ch, input int addr, input int data);
    qt_wr_en   = 1'b1;
    qt_wr_ch   = CH_W'(ch);
    qt_wr_addr = 6'(addr);
    qt_wr_data = Q_W'(data);
    tick();
    qt_wr_en = 1'b0;
    if (ch < NCH) qt_m[ch][addr] = data;
  endtask

  // Called one cycle after the accepted valid_in; returns cycles since valid_in.
  task automatic wait_valid(output int lat);
    lat = 1;
    while (!valid_out && lat < 20) begin
      tick();
      lat++;
    end
    if (!valid_out) lat = -1;
  endtask

  task automatic run_exp(input string name, input blk_t b, input int ch, input blk_t e);
    int lat;
    drive_blk(b);
    ch_in    = CH_W'(ch);
    valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
    check({name, " busy"}, int'(busy), 1);
    wait_valid(lat);
    check({name, " latency"}, lat, 9);
    check_blk({name, " data"}, e);
    check({name, " ch_out"}, int'(ch_out), ch);
    tick();
    check({name, " pulse"}, int'(valid_out), 0);
    check({name, " idle"}, int'(busy), 0);
  endtask

  task automatic run_block(input string name, input blk_t b, input int ch);
    blk_t e;
    model(b, ch, e);
    run_exp(name, b, ch, e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    blk_t b, e, z;
    int   n, lat, ch;

    vecs[0] = '{ch:1, x00:-3,    xr:-3,    e00:-48,   er:-48};
`ifdef DEQUANT_SAT_EN
    vecs[1] = '{ch:2, x00:2047,  xr:5,     e00:32767, er:5};
    vecs[2] = '{ch:2, x00:-2048, xr:-7,    e00:-32768, er:-7};
`else
    vecs[1] = '{ch:2, x00:2047,  xr:5,     e00:-2303, er:5};
    vecs[2] = '{ch:2, x00:-2048, xr:-7,    e00:2048,  er:-7};
`endif
    vecs[3] = '{ch:3, x00:100,   xr:-1,    e00:100,   er:-1};
    vecs[4] = '{ch:0, x00:2047,  xr:-2048, e00:2047,  er:-2048};
    vecs[5] = '{ch:1, x00:2047,  xr:-2048, e00:32752, er:-32768};
    vecs[6] = '{ch:1, x00:0,     xr:1,     e00:0,     er:16};

    rst_n = 1'b0; valid_in = 1'b0; ch_in = '0; block_in = '0;
    qt_wr_en = 1'b0; qt_wr_ch = '0; qt_wr_addr = '0; qt_wr_data = '0;
    model_reset();
    fill(z, 0, 0);
    tick(); tick();
    check("reset busy", int'(busy), 0);
    check("reset valid_out", int'(valid_out), 0);
    check("reset ch_out", int'(ch_out), 0);
    check("reset overrun", int'(overrun), 0);
    check_blk("reset block_out", z);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Identity tables after reset: output equals sign-extended input.
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        b[r][c] = r * 8 + c - 32;
    run_exp("ramp", b, 0, b);

    // Table setup for the vector table; channel 3 write must be dropped.
    for (int a = 0; a < 64; a++) qt_write(1, a, 16);
    qt_write(2, 0, 255);
    qt_write(3, 0, 9);
    for (int i = 0; i < 7; i++) begin
      fill(b, vecs[i].x00, vecs[i].xr);
      fill(e, vecs[i].e00, vecs[i].er);
      run_exp($sformatf("vec%0d", i), b, vecs[i].ch, e);
    end

    // Table writes racing the row reads of a block in progress.
    fill(b, 5, 5);
    drive_blk(b);
    ch_in = '0;
    valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
    qt_write(0, 0, 7);          // during row 0 read: row 0 keeps old value
    tick();
    qt_write(0, 56, 4);         // during row 2: row 7 sees new value
    tick(); tick(); tick(); tick();
    qt_write(0, 57, 9);         // during row 7 read: old value
    check("race latency", int'(valid_out), 1);
    fill(e, 5, 5);
    e[7][0] = 20;
    check_blk("race data", e);
    tick();
    // Write simultaneous with valid_in is visible to row 0.
    drive_blk(b);
    valid_in   = 1'b1;
    qt_wr_en   = 1'b1; qt_wr_ch = 2'd0; qt_wr_addr = 6'd1; qt_wr_data = 8'd3;
    tick();
    valid_in = 1'b0; qt_wr_en = 1'b0;
    qt_m[0][1] = 3;
    wait_valid(lat);
    check("race2 latency", lat, 9);
    fill(e, 35, 5);
    e[0][1] = 15; e[7][0] = 20; e[7][1] = 45;
    check_blk("race2 data", e);
    tick();

    // Randomized tables and blocks against the model.
    for (int it = 0; it < 3; it++) begin
      ch = int'($urandom_range(0, 3));
      for (int w = 0; w < 20; w++)
        qt_write(($urandom_range(0, 7) == 0) ? 3 : ch, int'($urandom_range(0, 63)),
                 ($urandom_range(0, 3) == 0) ? 255 : int'($urandom_range(0, 255)));
      for (int k = 0; k < 4; k++) begin
        for (int r = 0; r < 8; r++)
          for (int c = 0; c < 8; c++)
            b[r][c] = int'($urandom_range(0, 4095)) - 2048;
        run_block($sformatf("rand%0d_%0d", it, k), b, int'($urandom_range(0, 3)));
      end
    end

    // Overrun: second valid_in at T+4 is ignored.
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        b[r][c] = r - c;
    model(b, 0, e);
    drive_blk(b);
    ch_in = '0;
    valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
    tick(); tick(); tick();
    fill(z, 100, 100);
    drive_blk(z);
    ch_in = 2'd1;
    valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
    check("ovr flag", int'(overrun), 1);
    check("ovr busy", int'(busy), 1);
    n = 5;
    while (!valid_out && n < 30) begin
      tick();
      n++;
    end
    check("ovr latency", n, 9);
    check_blk("ovr data", e);
    check("ovr ch_out", int'(ch_out), 0);
    n = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (valid_out) n++;
    end
    check("ovr extra valid", n, 0);
    check("ovr sticky", int'(overrun), 1);

    // Reset in the middle of a block.
    fill(b, -3, -3);
    drive_blk(b);
    ch_in = 2'd1;
    valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
    tick(); tick(); tick(); tick();
    rst_n = 1'b0;
    #1;
    model_reset();
    fill(z, 0, 0);
    check("mid-reset busy", int'(busy), 0);
    check("mid-reset valid_out", int'(valid_out), 0);
    check("mid-reset ch_out", int'(ch_out), 0);
    check("mid-reset overrun", int'(overrun), 0);
    check_blk("mid-reset block_out", z);
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (valid_out) n++;
    end
    check("mid-reset no valid", n, 0);
    run_exp("post-reset identity", b, 1, b);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
